stochastic_bitstream_bank: RTL and testbench

- Multi-channel stochastic bitstream generator with signed values that can be reprogrammed at runtime.
- NUM_CH channels share one maximal-length Fibonacci LFSR. Each channel compares its own bit-rotated view of the LFSR, which decorrelates the channels.
- New values arrive through a valid/ready write port. They are held in shadow registers and committed together at epoch boundaries.
- Sits in front of stochastic arithmetic blocks (multipliers, adders) as the runtime-loadable operand source.

---
 rtl/stochastic_bitstream_bank_pkg.sv | 35 +++
 rtl/stochastic_bitstream_bank_if.sv | 14 +
 rtl/stochastic_bitstream_bank_channel.sv | 103 ++++++++++
 rtl/stochastic_bitstream_bank.sv | 101 ++++++++++
 tb/tb_stochastic_bitstream_bank.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/stochastic_bitstream_bank_pkg.sv
// Shared types and helpers for the stochastic bitstream bank: LFSR tap masks,
// channel configuration payload and a width-generic rotate-left.
package sbs_bank_pkg;

  localparam int unsigned MAX_W = 64;

  typedef struct packed {
    logic             neg;
    logic [MAX_W-1:0] value;
  } chan_cfg_t;

  // Fibonacci tap masks, bit k-1 set for polynomial term x^k (maximal length)
  function automatic logic [MAX_W-1:0] lfsr_taps(input int unsigned width);
    case (width)
      8:       return 64'h0000_0000_0000_00B8;
      16:      return 64'h0000_0000_0000_D008;
      20:      return 64'h0000_0000_0009_0000;
      32:      return 64'h0000_0000_8020_0003;
      64:      return 64'hD800_0000_0000_0000;
      default: return 64'h0;
    endcase
  endfunction

  function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] x,
                                            input int unsigned width,
                                            input int unsigned amt);
    logic [MAX_W-1:0] y;
    y = '0;
    for (int unsigned b = 0; b < MAX_W; b++) begin
      if (b < width) y[6'((b + amt) % width)] = x[6'(b)];
    end
    return y;
  endfunction

endpackage

// File: rtl/stochastic_bitstream_bank_if.sv
// Write port of the bank: valid/ready handshake carrying channel, magnitude and sign.
interface stochastic_bitstream_bank_if #(
  parameter int unsigned CH_W     = 2,
  parameter int unsigned BITWIDTH = 20
);
  logic                wr_valid;
  logic                wr_ready;
  logic [CH_W-1:0]     wr_ch;
  logic [BITWIDTH-1:0] wr_value;
  logic                wr_neg;

  modport master (output wr_valid, wr_ch, wr_value, wr_neg, input wr_ready);
  modport slave  (input wr_valid, wr_ch, wr_value, wr_neg, output wr_ready);
endinterface

// File: rtl/stochastic_bitstream_bank_channel.sv
// One bank channel: shadow/active values, pending flag, compare and output registers.
// Under SBS_BANK_ONES_COUNT_EN it also counts output ones per epoch.
module sbs_channel
  import sbs_bank_pkg::*;
#(
  parameter int unsigned BITWIDTH = 20,
  parameter int unsigned ROT      = 0
`ifdef SBS_BANK_ONES_COUNT_EN
  , parameter int unsigned CNT_W  = 11
`endif
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                en_i,
  input  logic                boundary_i,
  input  logic [BITWIDTH-1:0] lfsr_i,
  input  logic                wr_sel_i,
  input  chan_cfg_t           wr_cfg_i,
  output logic                out_p_o,
  output logic                out_m_o,
  output logic                pending_o
`ifdef SBS_BANK_ONES_COUNT_EN
  , output logic [CNT_W-1:0]  ones_o
`endif
);

  chan_cfg_t shadow_q, shadow_d, active_q, active_d;
  logic      pending_q, pending_d;
  logic      out_p_q, out_p_d, out_m_q, out_m_d;
  logic      hit_c;

  assign hit_c = rotl(MAX_W'(lfsr_i), BITWIDTH, ROT) < active_q.value;

  // Commit never coincides with a write: the bank deasserts ready on boundary
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    out_p_d   = out_p_q;
    out_m_d   = out_m_q;
    if (boundary_i && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (wr_sel_i) begin
      shadow_d  = wr_cfg_i;
      pending_d = 1'b1;
    end
    if (en_i) begin
      out_p_d = hit_c && !active_q.neg;
      out_m_d = hit_c && active_q.neg;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      out_p_q   <= 1'b0;
      out_m_q   <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      out_p_q   <= out_p_d;
      out_m_q   <= out_m_d;
    end
  end

  assign out_p_o   = out_p_q;
  assign out_m_o   = out_m_q;
  assign pending_o = pending_q;

`ifdef SBS_BANK_ONES_COUNT_EN
  logic [CNT_W-1:0] acc_q, acc_d, ones_q, ones_d, inc_c;

  assign inc_c = CNT_W'(out_p_q | out_m_q);

  always_comb begin
    acc_d  = acc_q;
    ones_d = ones_q;
    if (en_i) acc_d = acc_q + inc_c;
    if (boundary_i) begin
      ones_d = acc_q + inc_c;
      acc_d  = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_q  <= '0;
      ones_q <= '0;
    end else begin
      acc_q  <= acc_d;
      ones_q <= ones_d;
    end
  end

  assign ones_o = ones_q;
`endif

endmodule

// File: rtl/stochastic_bitstream_bank.sv
// Multi-channel signed stochastic bitstream bank around one shared Fibonacci LFSR.
// Optional per-channel epoch ones counter under SBS_BANK_ONES_COUNT_EN.
module stochastic_bitstream_bank
  import sbs_bank_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned BITWIDTH  = 20,
  parameter int unsigned EPOCH_LEN = 1024,
  parameter int unsigned ROT_STEP  = 3,
  parameter logic [63:0] SEED      = 64'd1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     en,
  stochastic_bitstream_bank_if.slave wr,
  output logic [NUM_CH-1:0]        out_p,
  output logic [NUM_CH-1:0]        out_m,
  output logic                     epoch_start,
  output logic [NUM_CH-1:0]        pending
`ifdef SBS_BANK_ONES_COUNT_EN
  , output logic [NUM_CH*($clog2(EPOCH_LEN)+1)-1:0] ones_count
`endif
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned EC_W = $clog2(EPOCH_LEN);
  localparam logic [BITWIDTH-1:0] TAPS   = BITWIDTH'(lfsr_taps(BITWIDTH));
  localparam logic [BITWIDTH-1:0] SEED_W = BITWIDTH'(SEED);
`ifdef SBS_BANK_ONES_COUNT_EN
  localparam int unsigned CNT_W = EC_W + 1;
`endif

  if (SEED_W == '0) begin : g_seed_chk
    $error("SEED must be nonzero");
  end
  if (TAPS == '0) begin : g_width_chk
    $error("BITWIDTH must be one of 8, 16, 20, 32, 64");
  end

  logic [BITWIDTH-1:0] lfsr_q, lfsr_d;
  logic [EC_W-1:0]     cnt_q, cnt_d;
  logic                epoch_start_q, epoch_start_d;
  logic                boundary_c, wr_fire_c;
  chan_cfg_t           wr_cfg_c;

  assign boundary_c  = en && (cnt_q == EC_W'(EPOCH_LEN - 1));
  assign wr.wr_ready = !RST && !boundary_c;
  assign wr_fire_c   = wr.wr_valid && wr.wr_ready;
  assign wr_cfg_c.neg   = wr.wr_neg;
  assign wr_cfg_c.value = MAX_W'(wr.wr_value);

  always_comb begin
    lfsr_d        = lfsr_q;
    cnt_d         = cnt_q;
    epoch_start_d = boundary_c;
    if (en) begin
      lfsr_d = {lfsr_q[BITWIDTH-2:0], ^(lfsr_q & TAPS)};
      cnt_d  = boundary_c ? '0 : cnt_q + EC_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      lfsr_q        <= SEED_W;
      cnt_q         <= '0;
      epoch_start_q <= 1'b0;
    end else begin
      lfsr_q        <= lfsr_d;
      cnt_q         <= cnt_d;
      epoch_start_q <= epoch_start_d;
    end
  end

  assign epoch_start = epoch_start_q;

  // Out-of-range channel indices match no channel, so such writes vanish
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sbs_channel #(
      .BITWIDTH (BITWIDTH),
      .ROT      ((i * ROT_STEP) % BITWIDTH)
`ifdef SBS_BANK_ONES_COUNT_EN
      , .CNT_W  (CNT_W)
`endif
    ) u_ch (
      .CLK        (CLK),
      .RST        (RST),
      .en_i       (en),
      .boundary_i (boundary_c),
      .lfsr_i     (lfsr_q),
      .wr_sel_i   (wr_fire_c && (wr.wr_ch == CH_W'(i))),
      .wr_cfg_i   (wr_cfg_c),
      .out_p_o    (out_p[i]),
      .out_m_o    (out_m[i]),
      .pending_o  (pending[i])
`ifdef SBS_BANK_ONES_COUNT_EN
      , .ones_o   (ones_count[i*CNT_W +: CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_stochastic_bitstream_bank.sv
// Randomized self-checking bench for stochastic_bitstream_bank against a behavioural model.
module tb_stochastic_bitstream_bank;

  localparam int unsigned NUM_CH    = 3;
  localparam int unsigned BITWIDTH  = 8;
  localparam int unsigned EPOCH_LEN = 255;
  localparam int unsigned ROT_STEP  = 3;
  localparam int unsigned CH_W      = 2;
  localparam int          SEED      = 1;

  logic clk = 1'b0;
  logic rst, en;
  logic [NUM_CH-1:0] out_p, out_m, pending;
  logic epoch_start;
`ifdef SBS_BANK_ONES_COUNT_EN
  logic [NUM_CH*($clog2(EPOCH_LEN)+1)-1:0] ones_count;
`endif

  stochastic_bitstream_bank_if #(.CH_W(CH_W), .BITWIDTH(BITWIDTH)) wr_if ();

  stochastic_bitstream_bank #(
    .NUM_CH(NUM_CH), .BITWIDTH(BITWIDTH), .EPOCH_LEN(EPOCH_LEN),
    .ROT_STEP(ROT_STEP), .SEED(64'd1)
  ) dut (
    .CLK(clk), .RST(rst), .en(en), .wr(wr_if),
    .out_p(out_p), .out_m(out_m), .epoch_start(epoch_start), .pending(pending)
`ifdef SBS_BANK_ONES_COUNT_EN
    , .ones_count(ones_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  int m_lfsr = SEED;
  int m_cnt = 0;
  int m_sh_val[NUM_CH];
  int m_act_val[NUM_CH];
  bit m_sh_neg[NUM_CH];
  bit m_act_neg[NUM_CH];
  bit [NUM_CH-1:0] m_pend = '0;
  bit [NUM_CH-1:0] e_p = '0, e_m = '0;
  bit e_es = 1'b0;
  bit last_rdy, last_dut_rdy;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lfsr_next(input int s);
    int fb;
    fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1;
    return ((s << 1) | fb) & 255;
  endfunction

  function automatic int rotl8(input int x, input int r);
    return ((x << r) | (x >> (BITWIDTH - r))) & 255;
  endfunction

  // One clock: check ready before the edge, advance the model, check registered outputs
  task automatic cycle();
    bit bnd, hit;
    #2;
    bnd = en && (m_cnt == EPOCH_LEN - 1);
    last_rdy = !rst && !bnd;
    last_dut_rdy = wr_if.wr_ready;
    check("wr_ready", wr_if.wr_ready, last_rdy);
    @(posedge clk);
    if (rst) begin
      m_lfsr = SEED; m_cnt = 0; e_p = '0; e_m = '0; e_es = 1'b0; m_pend = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_sh_val[c] = 0; m_act_val[c] = 0; m_sh_neg[c] = 0; m_act_neg[c] = 0;
      end
    end else begin
      if (en) begin
        for (int c = 0; c < NUM_CH; c++) begin
          hit = rotl8(m_lfsr, (c * ROT_STEP) % BITWIDTH) < m_act_val[c];
          e_p[c] = hit && !m_act_neg[c];
          e_m[c] = hit && m_act_neg[c];
        end
      end
      if (bnd) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (m_pend[c]) begin
            m_act_val[c] = m_sh_val[c]; m_act_neg[c] = m_sh_neg[c]; m_pend[c] = 1'b0;
          end
        end
      end
      if (wr_if.wr_valid && last_rdy && int'(wr_if.wr_ch) < NUM_CH) begin
        m_sh_val[wr_if.wr_ch] = int'(wr_if.wr_value);
        m_sh_neg[wr_if.wr_ch] = wr_if.wr_neg;
        m_pend[wr_if.wr_ch]   = 1'b1;
      end
      if (en) begin
        m_lfsr = lfsr_next(m_lfsr);
        m_cnt  = (m_cnt + 1) % EPOCH_LEN;
      end
      e_es = bnd;
    end
    #1;
    check("out_p", out_p, e_p);
    check("out_m", out_m, e_m);
    check("epoch_start", epoch_start, e_es);
    check("pending", pending, m_pend);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_write(input int ch, input int val, input bit neg);
    bit ok;
    ok = 1'b0;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_ch    = CH_W'(ch);
    wr_if.wr_value = BITWIDTH'(val);
    wr_if.wr_neg   = neg;
    for (int i = 0; i < 4 && !ok; i++) begin
      cycle();
      ok = last_dut_rdy;
    end
    wr_if.wr_valid = 1'b0;
    check("wr_accept", ok, 1'b1);
  endtask

  task automatic wait_epoch();
    bit found;
    found = 1'b0;
    for (int i = 0; i < EPOCH_LEN + 2 && !found; i++) begin
      cycle();
      found = e_es;
    end
    check("epoch_wait", found, 1'b1);
  endtask

  task automatic count_ones(input int ch, output int np, output int nm);
    np = 0; nm = 0;
    for (int i = 0; i < EPOCH_LEN; i++) begin
      cycle();
      np += int'(out_p[ch]);
      nm += int'(out_m[ch]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p0, p1, npulse, np, nm, np2, nm2, val;
    rst = 1'b1; en = 1'b0;
    wr_if.wr_valid = 1'b1; wr_if.wr_ch = 2'd2; wr_if.wr_value = 8'd99; wr_if.wr_neg = 1'b0;
    idle(3);
    rst = 1'b0; wr_if.wr_valid = 1'b0; en = 1'b1;

    // Two epochs with no writes: zero streams, pulses at 255 and 510
    p0 = -1; p1 = -1; npulse = 0;
    for (int i = 1; i <= 2 * EPOCH_LEN; i++) begin
      cycle();
      if (epoch_start) begin
        if (npulse == 0) p0 = i; else p1 = i;
        npulse++;
      end
    end
    check("es_first", p0, EPOCH_LEN);
    check("es_second", p1, 2 * EPOCH_LEN);
    check("es_count", npulse, 2);

    // Writes in one epoch, last write to ch0 wins
    idle(3);
    do_write(1, 128, 1'b0);
    do_write(0, 64, 1'b1);
    do_write(0, 200, 1'b0);
    check("pend_after_wr", pending, 3'b011);
    wait_epoch();
    count_ones(1, np, nm);
    check("ch1_ones_p", np, 127);
    check("ch1_ones_m", nm, 0);
    wait_epoch();
    count_ones(0, np, nm);
    check("ch0_ones_p", np, 199);
    check("ch0_ones_m", nm, 0);

    // Hold a write across a boundary
    for (int i = 0; i < EPOCH_LEN + 2 && m_cnt != EPOCH_LEN - 1; i++) cycle();
    wr_if.wr_valid = 1'b1; wr_if.wr_ch = 2'd2; wr_if.wr_value = 8'd50; wr_if.wr_neg = 1'b1;
    cycle();
    check("rdy_on_boundary", last_dut_rdy, 1'b0);
    cycle();
    check("rdy_after_boundary", last_dut_rdy, 1'b1);
    wr_if.wr_valid = 1'b0;
    check("pend_held_wr", pending[2], 1'b1);
    wait_epoch();
    count_ones(2, np, nm);
    check("ch2_ones_m", nm, 49);
    check("ch2_ones_p", np, 0);

    // Freeze with en low mid-epoch
    idle(100);
    en = 1'b0;
    idle(10);
    en = 1'b1;
    idle(50);

    // Out-of-range channel, then reset with pending writes
    do_write(3, 200, 1'b0);
    check("discard_pend", pending, 3'b000);
    do_write(1, 100, 1'b0);
    do_write(2, 77, 1'b1);
    check("pend_pre_rst", pending, 3'b110);
    rst = 1'b1;
    wr_if.wr_valid = 1'b1; wr_if.wr_ch = 2'd0; wr_if.wr_value = 8'd9; wr_if.wr_neg = 1'b0;
    cycle();
    rst = 1'b0; wr_if.wr_valid = 1'b0;
    check("pend_post_rst", pending, 3'b000);
    check("outp_post_rst", out_p, 3'b000);
    wait_epoch();
    count_ones(1, np, nm);
    count_ones(2, np2, nm2);
    check("rst_no_commit_1", np + nm, 0);
    check("rst_no_commit_2", np2 + nm2, 0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 7) != 0);
      rst = ($urandom_range(0, 399) == 0);
      wr_if.wr_valid = ($urandom_range(0, 3) == 0);
      wr_if.wr_ch = CH_W'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0:       val = 0;
        1:       val = 255;
        default: val = int'($urandom_range(0, 255));
      endcase
      wr_if.wr_value = BITWIDTH'(val);
      wr_if.wr_neg = 1'($urandom_range(0, 1));
      cycle();
    end
    rst = 1'b0; wr_if.wr_valid = 1'b0; en = 1'b1;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
